v_instr_queue: RTL
==================

Name: v_instr_queue

Overview:
- Vector instruction queue between the scalar core issue stage and v_decoder.
- Accepts vector instructions plus their scalar operands (rs1/rs2 values) from the scalar core.
- Buffers them in order and presents the head entry to v_decoder and the vector back-end through a valid/ready handshake.
- Holds vsetvl/vsetvli at the head until the back-end is idle, so vtype/vl never change mid-operation.

Parameters:
DEPTH, 4, number of queue entries; power of 2, 2..16
XLEN, 32, width of scalar operand fields

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  discard all entries (scalar-side trap/branch kill)
in_valid  input  1  scalar core offers an instruction
in_ready  output  1  queue can accept this cycle
in_instr  input  32  raw instruction word
in_rs1_data  input  XLEN  value of x[rs1] read by scalar core
in_rs2_data  input  XLEN  value of x[rs2] (stride for strided ld/st)
out_valid  output  1  head entry is issuable
out_ready  input  1  back-end accepts head this cycle
out_instr  output  32  head instruction word, to v_decoder instr
out_rs1_data  output  XLEN  head rs1 value
out_rs2_data  output  XLEN  head rs2 value
v_busy  input  1  vector back-end has an operation in flight
count  output  $clog2(DEPTH)+1  number of valid entries
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Storage: DEPTH-entry circular buffer of {instr, rs1_data, rs2_data}.
- Pointers: wr_ptr/rd_ptr, each $clog2(DEPTH)+1 bits; extra MSB distinguishes full from empty. Index = low bits, wraps modulo DEPTH.
- Reset (rst=1 at clock edge): wr_ptr=rd_ptr=0, count=0.
  - Resulting outputs: empty=1, full=0, in_ready=1, out_valid=0.
  - out_instr/out_rs1_data/out_rs2_data = 0 (storage cleared).
- Vector filter: an instruction is vector iff in_instr[6:0] is 7'b1010111 (OP-V), 7'b0000111 (LOAD-FP) or 7'b0100111 (STORE-FP).
- in_ready = !full.
- Enqueue fire = in_valid && in_ready.
  - Vector instr: written at wr_ptr, wr_ptr+1.
  - Non-vector instr: consumed (handshake completes) but not stored; pointers unchanged.
- Head is vconfig when out_instr[6:0]==7'b1010111 and out_instr[14:12]==3'b111.
- out_valid = !empty && !(head is vconfig && v_busy).
- Dequeue fire = out_valid && out_ready; rd_ptr+1.
- out_* are driven from the head entry whenever !empty. Fields are stable while out_valid=1 and out_ready=0.
- Latency: an instruction enqueued at edge N is visible on out_* in the cycle after edge N (1 cycle). Throughput is 1 instr/cycle.
- Same-cycle enqueue and dequeue when 0<count<DEPTH: count unchanged, both pointers advance.
- Full: in_ready=0, so no enqueue. Dequeue in that cycle frees one slot; in_ready rises the next cycle (no same-cycle pass-through).
- Empty: out_valid=0; out_ready is ignored.
- flush=1: at the next edge both pointers=0 and count=0. Flush has priority over any enqueue or dequeue in the same cycle; the entry offered by in_valid is dropped.
- rst mid-operation: same effect as flush. Also zeroes storage.
- count = wr_ptr - rd_ptr, width-truncated; full/empty derived combinationally from count.
- No other output depends on in_* combinationally, except in the bypass path below.

Optional Feature:
- Macro: V_IQ_BYPASS_EN
- Defined:
  - When empty and an enqueue fires with a vector instruction, out_instr/out_rs1_data/out_rs2_data = in_* combinationally, and out_valid follows the vconfig/v_busy rule.
  - If out_ready=1 in that cycle, the entry is consumed without being written (0-cycle latency); otherwise it is written normally.
  - flush=1 suppresses the bypass.
- Not defined: bypass absent; minimum latency is 1 cycle as above.

Test Plan:
- Reset then enqueue vadd.vv (0x02208057), out_ready=1 -> out_valid=1 one cycle later with out_instr=0x02208057; count returns to 0 after the dequeue.
- DEPTH=4, out_ready=0, push 5 vector instrs -> first 4 accepted, full=1, in_ready=0 on the 5th; pop one -> in_ready=1 next cycle, FIFO order preserved.
- Enqueue vsetvli (0x0D0072D7, funct3=111) with v_busy=1 -> out_valid=0 while busy; drop v_busy -> out_valid=1 the same cycle.
- Enqueue scalar addi (0x00100093) -> handshake completes, count stays 0, out_valid stays 0.
- count=2, simultaneous enqueue+dequeue for 6 cycles -> count stays 2, pointers wrap past DEPTH, data order correct.
- count=3 with flush=1 and in_valid=1 -> next cycle count=0, empty=1, offered instr lost. With V_IQ_BYPASS_EN and the queue empty: enqueue with out_ready=1 -> same-cycle out_valid and out_instr equal to in_instr, count stays 0.

Source files
------------

// File: rtl/v_instr_queue.sv
// Vector instruction queue between scalar issue and v_decoder; holds vsetvl(i) at the head while the back-end is busy.
// Optional zero-latency bypass into an empty queue: define V_IQ_BYPASS_EN.
module v_instr_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [XLEN-1:0]        in_rs1_data,
    input  logic [XLEN-1:0]        in_rs2_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [XLEN-1:0]        out_rs1_data,
    output logic [XLEN-1:0]        out_rs2_data,
    input  logic                   v_busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [6:0] OP_V        = 7'b1010111;
    localparam logic [6:0] OP_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OP_STORE_FP = 7'b0100111;

    logic [AW:0]      wr_ptr_reg, wr_ptr_next;
    logic [AW:0]      rd_ptr_reg, rd_ptr_next;
    logic [31:0]      instr_mem [DEPTH];
    logic [XLEN-1:0]  rs1_mem   [DEPTH];
    logic [XLEN-1:0]  rs2_mem   [DEPTH];
    logic [31:0]      head_instr;
    logic [XLEN-1:0]  head_rs1;
    logic [XLEN-1:0]  head_rs2;
    logic             is_vector;
    logic             enq_fire;
    logic             deq_fire;
    logic             wr_en;
    logic             bypass;
    logic             head_vconfig;

    assign count    = wr_ptr_reg - rd_ptr_reg;
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;

    assign is_vector = (in_instr[6:0] == OP_V) || (in_instr[6:0] == OP_LOAD_FP) ||
                       (in_instr[6:0] == OP_STORE_FP);
    assign enq_fire  = in_valid && in_ready;

    assign head_instr = instr_mem[rd_ptr_reg[AW-1:0]];
    assign head_rs1   = rs1_mem[rd_ptr_reg[AW-1:0]];
    assign head_rs2   = rs2_mem[rd_ptr_reg[AW-1:0]];

`ifdef V_IQ_BYPASS_EN
    assign bypass       = empty && enq_fire && is_vector && !flush;
    assign out_instr    = bypass ? in_instr    : head_instr;
    assign out_rs1_data = bypass ? in_rs1_data : head_rs1;
    assign out_rs2_data = bypass ? in_rs2_data : head_rs2;
`else
    assign bypass       = 1'b0;
    assign out_instr    = head_instr;
    assign out_rs1_data = head_rs1;
    assign out_rs2_data = head_rs2;
`endif

    // vsetvl/vsetvli must wait for an idle back-end so vtype/vl never change mid-op
    assign head_vconfig = (out_instr[6:0] == OP_V) && (out_instr[14:12] == 3'b111);
    assign out_valid    = (!empty || bypass) && !(head_vconfig && v_busy);
    assign deq_fire     = out_valid && out_ready;

    // A bypassed entry that is consumed in the same cycle never touches storage
    assign wr_en = enq_fire && is_vector && !flush && !(bypass && deq_fire);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (wr_en)
                wr_ptr_next = wr_ptr_reg + 1'b1;
            if (deq_fire && !bypass)
                rd_ptr_next = rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    instr_mem[gi] <= '0;
                    rs1_mem[gi]   <= '0;
                    rs2_mem[gi]   <= '0;
                end else if (wr_en && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
                    instr_mem[gi] <= in_instr;
                    rs1_mem[gi]   <= in_rs1_data;
                    rs2_mem[gi]   <= in_rs2_data;
                end
            end
        end
    endgenerate
endmodule
